// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arith_pkg
// Description : Shared state encoding, mode constants and the elaboration
//               check for the chunked add/subtract unit.
// Revision    : 1.0 - initial release
// ============================================================================

// Elaboration guard: the operand width must split into whole chunks.
`ifndef ARITH_CHECK_DIV
`define ARITH_CHECK_DIV(W, C) \
  if (((C) < 1) || ((C) > (W)) || (((W) % (C)) != 0)) begin : g_bad_chunk \
    $error("arith: WIDTH must be a positive multiple of CHUNK"); \
  end
`endif

package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Chunk counter width; a single-chunk configuration still needs one bit.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fa_chunk.sv
`default_nettype none
// ============================================================================
// Module      : fa_chunk
// Description : Combinational N-bit ripple-carry adder built from 1-bit
//               full-adder cells. Also exposes the carry into the top bit so
//               the caller can form signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         c_msb
);

  logic [N:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[N];
  assign c_msb = c[N-1];

endmodule

`default_nettype wire

// File: rtl/seq_addsub_chunked.sv
`default_nettype none
// ============================================================================
// Module      : seq_addsub_chunked
// Description : Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK
//               bits per clock, LSB chunk first, with a registered carry
//               between chunks and a start/ready/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_addsub_chunked
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  `ARITH_CHECK_DIV(WIDTH, CHUNK)

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_co;
  logic             ch_cmsb;

  logic             accept;
  logic             last;

  // One chunk of the addition per cycle on the low bits of the operand shifters.
  fa_chunk #(
    .N(CHUNK)
  ) u_fa_chunk (
    .a    (op_a[CHUNK-1:0]),
    .b    (op_b[CHUNK-1:0]),
    .ci   (carry),
    .sum  (ch_sum),
    .co   (ch_co),
    .c_msb(ch_cmsb)
  );

  // New chunk enters at the top; after NCHUNK shifts the result is aligned.
  assign acc_nxt = WIDTH'({ch_sum, acc} >> CHUNK);

  // Next-state logic and one-cycle control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == LAST_CNT) begin
          last      = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture on accept, then chunk-wise shifting while running.
  // Subtraction is folded into the capture: invert B and the borrow-in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= (mode == MODE_SUB) ? ~b : b;
      carry <= (mode == MODE_SUB) ? ~ci : ci;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      op_a  <= op_a >> CHUNK;
      op_b  <= op_b >> CHUNK;
      acc   <= acc_nxt;
      carry <= ch_co;
      cnt   <= cnt + CW'(1);
    end
  end

  // Result registers load only at completion so they hold between operations.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s    <= '0;
      co   <= 1'b0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        s   <= acc_nxt;
        co  <= ch_co;
        ovf <= ch_co ^ ch_cmsb;
      end
    end
  end

  assign ready = (state == ST_IDLE);
  assign busy  = (state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_seq_addsub_chunked.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_addsub_chunked
// Description : Self-checking bench for seq_addsub_chunked. A cycle model of
//               the handshake pushes expected results into a queue at accept
//               and the monitor pops and compares them when done is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_addsub_chunked;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start16, start1;
  logic        mode;
  logic [15:0] a, b;
  logic        ci;

  logic        ready, busy, done, co, ovf;
  logic [15:0] s;
  logic        ready16, busy16, done16, co16, ovf16;
  logic [15:0] s16;
  logic        ready1, busy1, done1, co1, ovf1;
  logic [15:0] s1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_addsub_chunked #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b), .ci(ci),
    .ready(ready), .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
  );

  seq_addsub_chunked #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode), .a(a), .b(b), .ci(ci),
    .ready(ready16), .busy(busy16), .done(done16), .s(s16), .co(co16), .ovf(ovf16)
  );

  seq_addsub_chunked #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .a(a), .b(b), .ci(ci),
    .ready(ready1), .busy(busy1), .done(done1), .s(s1), .co(co1), .ovf(ovf1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural reference: a + b + ci or a - b - ci, overflow from operand signs.
  function automatic exp_t ref_model(input logic m, input logic [15:0] x, input logic [15:0] y,
                                     input logic c);
    logic [16:0] r;
    logic [15:0] yy;
    exp_t        e;
    yy = m ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {16'd0, (m ? ~c : c)};
    e.s   = r[15:0];
    e.co  = r[16];
    e.ovf = (x[15] == yy[15]) && (r[15] != x[15]);
    return e;
  endfunction

  // Handshake model of the CHUNK=4 instance.
  exp_t exp_q[$];
  exp_t held;
  int   m_left   = 0;
  bit   mon_en   = 0;
  bit   in_rand  = 0;
  int   rand_acc = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0;
      exp_q.delete();
      held = '0;
    end else if (m_left == 0) begin
      if (start) begin
        exp_q.push_back(ref_model(mode, a, b, ci));
        m_left = NCHUNK + 1;
        if (in_rand) rand_acc++;
      end
    end else begin
      m_left--;
    end
  end

  int cyc = 0;
  int last_done_cyc = 0;
  int rand_dones = 0;

  // Monitor: handshake outputs every cycle, results held between completions.
  always @(negedge clk) begin
    cyc++;
    if (mon_en && rst_n) begin
      if (m_left == 1 && exp_q.size() > 0) held = exp_q.pop_front();
      check_val("ready", ready, (m_left == 0));
      check_val("busy",  busy,  (m_left > 1));
      check_val("done",  done,  (m_left == 1));
      check_val("s",     s,     held.s);
      check_val("co",    co,    held.co);
      check_val("ovf",   ovf,   held.ovf);
      if (done && in_rand) begin
        if (rand_dones > 0) check_val("spacing", cyc - last_done_cyc, NCHUNK + 2);
        rand_dones++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic issue(input logic m, input logic [15:0] x, input logic [15:0] y, input logic c);
    int n;
    n = 0;
    while (m_left != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_val("idle_timeout", 1, 0);
    mode = m; a = x; b = y; ci = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles from the accept edge until done is seen (first post-accept cycle = 1).
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_val("done_timeout", 1, 0);
  endtask

  task automatic run_op(input string tag, input logic m, input logic [15:0] x,
                        input logic [15:0] y, input logic c,
                        input logic [15:0] es, input logic eco, input logic eovf);
    int n;
    issue(m, x, y, c);
    wait_done(n);
    check_val({tag, "_lat"}, n, NCHUNK + 1);
    check_val({tag, "_s"},   s,   es);
    check_val({tag, "_co"},  co,  eco);
    check_val({tag, "_ovf"}, ovf, eovf);
  endtask

  task automatic sweep(input int which, input int exp_lat);
    int n;
    mode = 1'b0; a = 16'hFFFF; b = 16'h0001; ci = 1'b0;
    if (which == 16) start16 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; start1 = 1'b0;
    n = 1;
    while (!((which == 16) ? done16 : done1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (which == 16) begin
      check_val("c16_lat", n, exp_lat);
      check_val("c16_s", s16, 16'h0000);
      check_val("c16_co", co16, 1'b1);
    end else begin
      check_val("c1_lat", n, exp_lat);
      check_val("c1_s", s1, 16'h0000);
      check_val("c1_co", co1, 1'b1);
    end
  endtask

  initial begin
    int n;
    int dones;
    rst_n = 1'b0; start = 1'b0; start16 = 1'b0; start1 = 1'b0;
    mode = 1'b0; a = '0; b = '0; ci = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", ready, 1'b1);
    check_val("rst_busy",  busy,  1'b0);
    check_val("rst_done",  done,  1'b0);
    check_val("rst_s",     s,     16'h0000);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    run_op("add",   1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("chain", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("povf",  1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub1",  1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub2",  1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub3",  1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b0);

    // Start pulse and operand changes while running must be ignored.
    issue(1'b0, 16'h0001, 16'h0001, 1'b0);
    a = 16'hAAAA; b = 16'h1357; mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'h0F0F;
    wait_done(n);
    check_val("ign_s", s, 16'h0002);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_val("ign_second_done", dones, 0);

    // Reset during the second RUN cycle aborts without a done.
    issue(1'b0, 16'h00FF, 16'h0F0F, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("abort_s",     s,     16'h0000);
    check_val("abort_co",    co,    1'b0);
    check_val("abort_ovf",   ovf,   1'b0);
    check_val("abort_done",  done,  1'b0);
    check_val("abort_ready", ready, 1'b1);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_val("abort_no_done", dones, 0);

    sweep(16, 2);
    sweep(1, 17);

    // Back-to-back random operations with start held high.
    in_rand = 1'b1;
    start   = 1'b1;
    n = 0;
    while (rand_acc < 200 && n < 2000) begin
      mode = 1'($urandom);
      ci   = 1'($urandom);
      a    = 16'($urandom);
      b    = 16'($urandom);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (rand_acc < 200) check_val("rand_timeout", rand_acc, 200);
    repeat (NCHUNK + 4) @(negedge clk);
    check_val("rand_done_count", rand_dones, rand_acc);
    in_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
